// File: rtl/frogger_pkg.sv
// Shared timing defaults and repeat-FSM encoding for the button event controller.
package frogger_pkg;

   localparam int DEF_NUM_BUTTONS    = 4;
   localparam int DEF_DEBOUNCE_LIMIT = 250000;    // 10 ms at 25 MHz
   localparam int DEF_REPEAT_DELAY   = 12500000;  // 500 ms at 25 MHz
   localparam int DEF_REPEAT_PERIOD  = 3125000;   // 125 ms at 25 MHz

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/release pulses and
// auto-repeat FSM. All outputs are registered.
module button_channel
   import frogger_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
   parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Button,
   output logic       o_Debounced,
   output logic       o_Press,
   output logic       o_Release,
   output logic       o_Repeat,
   output rpt_state_e o_State
);

   localparam int DEB_W = $clog2(DEBOUNCE_LIMIT + 1);
   localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_LIMIT - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [1:0]       sync_q, sync_d;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             debounced_q, debounced_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             repeat_q, repeat_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   rpt_state_e       state_q, state_d;

   always_comb begin
      sync_d      = {sync_q[0], i_Button};
      deb_cnt_d   = '0;
      debounced_d = debounced_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      // The counter holds the number of differing cycles already seen, so the
      // toggle lands on the DEBOUNCE_LIMIT-th one.
      if (sync_q[1] != debounced_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            debounced_d = ~debounced_q;
            press_d     = ~debounced_q;
            release_d   = debounced_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      case (state_q)
         RPT_IDLE: begin
            if (press_d) begin
               state_d   = RPT_DELAY;
               rpt_cnt_d = '0;
               repeat_d  = 1'b1;
            end
         end
         RPT_DELAY: begin
            if (release_d) begin
               state_d   = RPT_IDLE;
               rpt_cnt_d = '0;
            end else if (REPEAT_DELAY != 0) begin
               if (rpt_cnt_q == DELAY_LAST) begin
                  state_d   = RPT_REPEAT;
                  rpt_cnt_d = '0;
                  repeat_d  = 1'b1;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
               end
            end
         end
         RPT_REPEAT: begin
            if (release_d) begin
               state_d   = RPT_IDLE;
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == PERIOD_LAST) begin
               rpt_cnt_d = '0;
               repeat_d  = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
         end
         default: begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         sync_q      <= '0;
         deb_cnt_q   <= '0;
         debounced_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         repeat_q    <= 1'b0;
         rpt_cnt_q   <= '0;
         state_q     <= RPT_IDLE;
      end else begin
         sync_q      <= sync_d;
         deb_cnt_q   <= deb_cnt_d;
         debounced_q <= debounced_d;
         press_q     <= press_d;
         release_q   <= release_d;
         repeat_q    <= repeat_d;
         rpt_cnt_q   <= rpt_cnt_d;
         state_q     <= state_d;
      end
   end

   assign o_Debounced = debounced_q;
   assign o_Press     = press_q;
   assign o_Release   = release_q;
   assign o_Repeat    = repeat_q;
   assign o_State     = state_q;

endmodule

// File: rtl/button_event_controller.sv
// Debounced multi-button front end with per-button press/release/repeat
// pulses and a one-shot chord detector.
module button_event_controller
   import frogger_pkg::*;
#(
   parameter int                     NUM_BUTTONS    = DEF_NUM_BUTTONS,
   parameter int                     DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
   parameter int                     REPEAT_DELAY   = DEF_REPEAT_DELAY,
   parameter int                     REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
   parameter logic [NUM_BUTTONS-1:0] CHORD_MASK     = '1
) (
   input  logic                         i_Clk,
   input  logic                         i_Reset,
   input  logic       [NUM_BUTTONS-1:0] i_Buttons,
   output logic       [NUM_BUTTONS-1:0] o_Debounced,
   output logic       [NUM_BUTTONS-1:0] o_Press,
   output logic       [NUM_BUTTONS-1:0] o_Release,
   output logic       [NUM_BUTTONS-1:0] o_Repeat,
   output logic                         o_Chord,
   output rpt_state_e [NUM_BUTTONS-1:0] o_Rpt_State
);

   logic chord_held_q, chord_held_d;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
      button_channel #(
         .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
         .i_Clk      (i_Clk),
         .i_Reset    (i_Reset),
         .i_Button   (i_Buttons[g]),
         .o_Debounced(o_Debounced[g]),
         .o_Press    (o_Press[g]),
         .o_Release  (o_Release[g]),
         .o_Repeat   (o_Repeat[g]),
         .o_State    (o_Rpt_State[g])
      );
   end

   // Rising edge of "chord held", aligned with the cycle the last button is accepted.
   always_comb begin
      chord_held_d = ((o_Debounced & CHORD_MASK) == CHORD_MASK);
      o_Chord      = chord_held_d & ~chord_held_q;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         chord_held_q <= 1'b0;
      end else begin
         chord_held_q <= chord_held_d;
      end
   end

endmodule

// File: tb/tb_button_event_controller.sv
// Table-driven bench for button_event_controller with a small debounce/repeat
// configuration; expected output vectors flow through a scoreboard queue.
module tb_button_event_controller;
   import frogger_pkg::*;

   localparam int NB   = 4;
   localparam int DL   = 4;
   localparam int RD   = 10;
   localparam int RP   = 3;
   localparam int LAT  = 2 + DL;
   localparam int NONE = 10000;
   localparam int VW   = 4 * NB + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NB-1:0]        btn;
   logic [NB-1:0]        deb, prs, rel, rpt;
   logic                 chord;
   rpt_state_e [NB-1:0]  st;

   always #5 clk = ~clk;

   button_event_controller #(
      .NUM_BUTTONS   (NB),
      .DEBOUNCE_LIMIT(DL),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .i_Clk      (clk),
      .i_Reset    (rst),
      .i_Buttons  (btn),
      .o_Debounced(deb),
      .o_Press    (prs),
      .o_Release  (rel),
      .o_Repeat   (rpt),
      .o_Chord    (chord),
      .o_Rpt_State(st)
   );

   typedef struct {
      logic [NB-1:0] raw;
      logic          rst;
      logic [VW-1:0] exp;  // {chord, repeat, release, press, debounced}
   } vec_t;

   vec_t          tbl[$];
   logic [VW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;
   string         scn;
   int            ra[NB], fa[NB], rb[NB], fb[NB];
   logic          chord_prev;

   // Expected {repeat, release, press, debounced} in observed cycle c for a
   // clean hold whose raw level is high in cycles [rise, fall).
   function automatic logic [3:0] chan_exp(input int c, input int rise, input int fall);
      int   a, b;
      logic d, p, l, q;
      a = rise + LAT;
      b = fall + LAT;
      d = (c >= a) && (c < b);
      p = (c == a);
      l = (c == b) && (b > a);
      q = d && ((c == a) || ((c - a) >= RD && ((c - a - RD) % RP) == 0));
      return {q, l, p, d};
   endfunction

   task automatic add_row(input logic [NB-1:0] raw, input logic r, input logic [VW-1:0] e);
      vec_t v;
      v.raw = raw;
      v.rst = r;
      v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic add_rep(input logic [NB-1:0] raw, input logic [VW-1:0] e, input int n);
      for (int k = 0; k < n; k++) add_row(raw, 1'b0, e);
   endtask

   task automatic clear_iv();
      for (int i = 0; i < NB; i++) begin
         ra[i] = NONE; fa[i] = NONE; rb[i] = NONE; fb[i] = NONE;
      end
      chord_prev = 1'b0;
   endtask

   // Rows r0..r1: row r drives the raw level of cycle r; its expectation is cycle r+1.
   task automatic build_iv(input int r0, input int r1);
      for (int r = r0; r <= r1; r++) begin
         logic [NB-1:0] raw, d, p, l, q;
         logic [3:0]    e;
         logic          all_now;
         for (int i = 0; i < NB; i++) begin
            raw[i] = ((r >= ra[i]) && (r < fa[i])) || ((r >= rb[i]) && (r < fb[i]));
            e = chan_exp(r + 1, ra[i], fa[i]) | chan_exp(r + 1, rb[i], fb[i]);
            {q[i], l[i], p[i], d[i]} = e;
         end
         all_now = &d;
         add_row(raw, 1'b0, {all_now & ~chord_prev, q, l, p, d});
         chord_prev = all_now;
      end
   endtask

   task automatic run_table();
      for (int k = 0; k < tbl.size(); k++) begin
         logic [VW-1:0] got, e;
         btn = tbl[k].raw;
         rst = tbl[k].rst;
         exp_q.push_back(tbl[k].exp);
         @(posedge clk);
         #1;
         got = {chord, rpt, rel, prs, deb};
         e   = exp_q.pop_front();
         n_checks++;
         if (got === e) n_pass++;
         else $display("FAIL %s row %0d: got %h expected %h", scn, k, got, e);
      end
      tbl.delete();
   endtask

   task automatic check_state(input string name, input logic [2*NB-1:0] e);
      n_checks++;
      if (st === e) n_pass++;
      else $display("FAIL %s: state got %h expected %h", name, st, e);
   endtask

   localparam logic [2*NB-1:0] ALL_IDLE = {RPT_IDLE, RPT_IDLE, RPT_IDLE, RPT_IDLE};

   initial begin
      int ch, f;
      logic [NB-1:0] b;
      rst = 1'b1;
      btn = '0;

      // Button 3 held through reset; press appears the normal latency after release.
      scn = "reset_hold";
      clear_iv();
      add_rep(4'b1000, '0, 0);
      for (int k = 0; k < 3; k++) add_row(4'b1000, 1'b1, '0);
      run_table();
      check_state("reset_state", ALL_IDLE);
      ra[3] = 0; fa[3] = 12;
      build_iv(0, 21);
      run_table();
      check_state("idle_after_reset_hold", ALL_IDLE);

      scn = "clean_press";
      clear_iv();
      ch = $urandom_range(0, NB - 1);
      f  = $urandom_range(15, 30);
      ra[ch] = 0; fa[ch] = f;
      build_iv(0, f + 9);
      run_table();

      // Raw 1,1,0,0 then steady 1: the window restarts at the last edge (cycle 4).
      scn = "bounce";
      b = 4'b0100;
      add_rep(b,  '0, 2);
      add_rep('0, '0, 2);
      add_rep(b,  '0, 5);
      add_row(b,  1'b0, {1'b0, b, 4'b0000, b, b});
      add_rep('0, {1'b0, 4'b0000, 4'b0000, 4'b0000, b}, 5);
      add_row('0, 1'b0, {1'b0, 4'b0000, b, 4'b0000, 4'b0000});
      add_rep('0, '0, 2);
      run_table();

      scn = "hold_repeat";
      clear_iv();
      ra[1] = 0; fa[1] = 36;
      build_iv(0, 47);
      run_table();

      // Staggered chord, then button 2 released and re-pressed for a second chord.
      scn = "chord";
      clear_iv();
      for (int i = 0; i < NB; i++) begin
         ra[i] = i; fa[i] = 40;
      end
      fa[2] = 20; rb[2] = 30; fb[2] = 40;
      build_iv(0, 51);
      run_table();

      scn = "simultaneous";
      clear_iv();
      for (int i = 0; i < NB; i++) begin
         ra[i] = 0; fa[i] = 12;
      end
      build_iv(0, 21);
      run_table();

      // Reset pulse while button 1 is auto-repeating.
      scn = "reset_mid_repeat";
      clear_iv();
      ra[1] = 0;
      build_iv(0, 8);
      run_table();
      check_state("state_delay", {RPT_IDLE, RPT_IDLE, RPT_DELAY, RPT_IDLE});
      build_iv(9, 16);
      run_table();
      check_state("state_repeat", {RPT_IDLE, RPT_IDLE, RPT_REPEAT, RPT_IDLE});
      add_row(4'b0010, 1'b1, '0);
      run_table();
      check_state("state_after_reset", ALL_IDLE);
      clear_iv();
      ra[1] = 18; fa[1] = 26;
      build_iv(18, 35);
      run_table();
      check_state("state_final", ALL_IDLE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
